// File: rtl/cache_memory_nway.sv
// Tag/data array for an N-way set-associative write-back cache.
// It does the tag lookup, word read/write, tree-PLRU victim choice,
// write-back read-out and refill.
module cache_memory_nway #(
  parameter int WORD_SIZE       = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int BLOCK_SIZE      = WORDS_PER_BLOCK * WORD_SIZE,
  parameter int NUM_BLOCKS      = 64,
  parameter int NUM_WAYS        = 2,
  parameter int NUM_SETS        = NUM_BLOCKS / NUM_WAYS,
  parameter int INDEX_WIDTH     = $clog2(NUM_SETS),
  parameter int OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK),
  parameter int TAG_WIDTH       = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TAG_WIDTH-1:0]    tag,
  input  logic [INDEX_WIDTH-1:0]  index,
  input  logic [OFFSET_WIDTH-1:0] blk_offset,
  input  logic                    req_type,
  input  logic                    read_en_cache,
  input  logic                    write_en_cache,
  input  logic                    read_en_mem,
  input  logic                    write_en_mem,
  input  logic [BLOCK_SIZE-1:0]   data_in_mem,
  input  logic [WORD_SIZE-1:0]    data_in,
  output logic [BLOCK_SIZE-1:0]   dirty_block_out,
  output logic                    hit,
  output logic [WORD_SIZE-1:0]    data_out,
  output logic                    dirty_bit
);

  localparam int WAY_W   = $clog2(NUM_WAYS);
  localparam int ENTRY_W = BLOCK_SIZE + TAG_WIDTH + 2;
  localparam int BLK_LSB = TAG_WIDTH + 2;

  // Entry layout: {block, tag, dirty, valid}
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][ENTRY_W-1:0] cache;
  logic [NUM_SETS-1:0][NUM_WAYS-2:0]              r_plru;
  logic [WAY_W-1:0]                               accessed_way;

  logic [WORD_SIZE-1:0]  r_data_out;
  logic [BLOCK_SIZE-1:0] r_dirty_block_out;

  logic                  w_hit;
  logic                  w_inv_found;
  logic [WAY_W-1:0]      w_hit_way;
  logic [WAY_W-1:0]      w_inv_way;
  logic [WAY_W-1:0]      w_victim;
  logic [BLOCK_SIZE-1:0] w_block;
  logic [WORD_SIZE-1:0]  w_word;

  // PLRU tree nodes are heap-ordered: node n has children 2n+1 (way bit 0)
  // and 2n+2 (way bit 1); each bit points toward the victim side.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
    int unsigned      node;
    logic [WAY_W-1:0] way;
    node = 0;
    way  = '0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      way[WAY_W-1-lvl] = bits[node];
      node = 2 * node + 1 + {31'b0, bits[node]};
    end
    return way;
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                     input logic [WAY_W-1:0]    way);
    logic [NUM_WAYS-2:0] nb;
    int unsigned         node;
    logic                wb;
    nb   = bits;
    node = 0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      wb       = way[WAY_W-1-lvl];
      nb[node] = ~wb;
      node     = 2 * node + 1 + {31'b0, wb};
    end
    return nb;
  endfunction

  // Tag match across the set, invalid-way search and victim selection
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (cache[index][w][0] && (cache[index][w][BLK_LSB-1:2] == tag) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!cache[index][w][0] && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
    w_victim     = plru_victim(r_plru[index]);
    accessed_way = w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_victim);
  end

  // Selected line, selected word and the combinational status outputs
  always_comb begin
    w_block   = cache[index][accessed_way][ENTRY_W-1 -: BLOCK_SIZE];
    w_word    = w_block[int'(blk_offset) * WORD_SIZE +: WORD_SIZE];
    hit       = w_hit;
    dirty_bit = !w_hit && cache[index][accessed_way][0] && cache[index][accessed_way][1];
  end

  // Prioritised array update: reset, refill, write-back, write hit, read hit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          cache[s][w][1:0] <= 2'b00;
        end
      end
      r_plru            <= '0;
      r_data_out        <= '0;
      r_dirty_block_out <= '0;
    end else if (read_en_mem && write_en_cache) begin
      cache[index][accessed_way] <= {data_in_mem, tag, 1'b0, 1'b1};
      r_plru[index]              <= plru_touch(r_plru[index], accessed_way);
    end else if (write_en_mem && read_en_cache) begin
      r_dirty_block_out <= w_block;
    end else if (write_en_cache && req_type && w_hit) begin
      cache[index][accessed_way][BLK_LSB + int'(blk_offset) * WORD_SIZE +: WORD_SIZE] <= data_in;
      cache[index][accessed_way][1] <= 1'b1;
      r_data_out                    <= data_in;
      r_plru[index]                 <= plru_touch(r_plru[index], accessed_way);
    end else if (read_en_cache && !req_type && w_hit) begin
      r_data_out    <= w_word;
      r_plru[index] <= plru_touch(r_plru[index], accessed_way);
    end
  end

  assign data_out        = r_data_out;
  assign dirty_block_out = r_dirty_block_out;

endmodule

// File: tb/tb_cache_memory_nway.sv
// Directed test of cache_memory_nway: hit/miss, PLRU victim choice,
// write-back read-out, refill, reset and invalid-way preference.
module tb_cache_memory_nway;

  logic         clk;
  logic         rst;
  logic [24:0]  tag;
  logic [4:0]   index;
  logic [1:0]   blk_offset;
  logic         req_type;
  logic         read_en_cache;
  logic         write_en_cache;
  logic         read_en_mem;
  logic         write_en_mem;
  logic [127:0] data_in_mem;
  logic [31:0]  data_in;
  logic [127:0] dirty_block_out;
  logic         hit;
  logic [31:0]  data_out;
  logic         dirty_bit;

  int n_tests = 0;
  int n_fail  = 0;

  cache_memory_nway #(
    .WORD_SIZE      (32),
    .WORDS_PER_BLOCK(4),
    .NUM_BLOCKS     (64),
    .NUM_WAYS       (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tag            (tag),
    .index          (index),
    .blk_offset     (blk_offset),
    .req_type       (req_type),
    .read_en_cache  (read_en_cache),
    .write_en_cache (write_en_cache),
    .read_en_mem    (read_en_mem),
    .write_en_mem   (write_en_mem),
    .data_in_mem    (data_in_mem),
    .data_in        (data_in),
    .dirty_block_out(dirty_block_out),
    .hit            (hit),
    .data_out       (data_out),
    .dirty_bit      (dirty_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] idx, input logic [24:0] tg, input logic [1:0] off,
                       input logic rt, input logic rec, input logic wec,
                       input logic rem, input logic wem,
                       input logic [31:0] din, input logic [127:0] dmem);
    index = idx; tag = tg; blk_offset = off; req_type = rt;
    read_en_cache = rec; write_en_cache = wec; read_en_mem = rem; write_en_mem = wem;
    data_in = din; data_in_mem = dmem;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [4:0] idx, input logic [24:0] tg, input logic [127:0] dmem);
    drive(idx, tg, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, dmem);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(5'd0, 25'h1ABCDE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_dirty_block_out", dirty_block_out, 0);
    chk("rst_hit", hit, 0);

    // Scenario 1: fill set 0, then write hit on way0
    refill(5'd0, 25'h1ABCDE, 128'hDEADBEEF_55667788_11223344_AABBCCDD);
    refill(5'd0, 25'h00C0FF, 128'hFACEB00C_DEADC0DE_C0FFEE11_12345678);
    drive(5'd0, 25'h1ABCDE, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11112222, 128'h0);
    chk("s1_hit", hit, 1);
    chk("s1_way", dut.accessed_way, 0);
    tick();
    chk("s1_block", dut.cache[0][0][154:27], 128'hDEADBEEF_11112222_11223344_AABBCCDD);
    chk("s1_dirty", dut.cache[0][0][1], 1);
    chk("s1_data_out", data_out, 32'h11112222);

    // Scenario 2: clean write miss, victim is way1
    drive(5'd0, 25'h012345, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h33334444, 128'h0);
    chk("s2_miss", hit, 0);
    chk("s2_victim", dut.accessed_way, 1);
    chk("s2_dirty_bit", dirty_bit, 0);
    tick();
    chk("s2_miss_hold_data", data_out, 32'h11112222);
    chk("s2_miss_hold_tag", dut.cache[0][1][26:2], 25'h00C0FF);
    refill(5'd0, 25'h012345, 128'hCAFEBABE_FEEDFACE_DEADBEAF_87654321);
    drive(5'd0, 25'h012345, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h33334444, 128'h0);
    chk("s2_refill_hit", hit, 1);
    chk("s2_refill_way", dut.accessed_way, 1);
    tick();
    chk("s2_block", dut.cache[0][1][154:27], 128'hCAFEBABE_FEEDFACE_33334444_87654321);

    // Scenario 3: dirty write miss in set 1
    refill(5'd1, 25'h02AAAA, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    drive(5'd1, 25'h02AAAA, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDDDDDDDD, 128'h0);
    tick();
    refill(5'd1, 25'h02BBBB, 128'h11111111_22222222_33333333_44444444);
    drive(5'd1, 25'h02BBBB, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    chk("s3_read_hit", hit, 1);
    chk("s3_read_way", dut.accessed_way, 1);
    tick();
    chk("s3_read_data", data_out, 32'h11111111);
    drive(5'd1, 25'h02CCCC, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h77778888, 128'h0);
    chk("s3_miss", hit, 0);
    chk("s3_victim", dut.accessed_way, 0);
    chk("s3_dirty_bit", dirty_bit, 1);
    drive(5'd1, 25'h02CCCC, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77778888, 128'h0);
    tick();
    chk("s3_writeback", dirty_block_out, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    refill(5'd1, 25'h02CCCC, 128'hFEEDFACE_DEADBEAF_CAFEBABE_12345678);
    drive(5'd1, 25'h02CCCC, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h77778888, 128'h0);
    chk("s3_write_hit", hit, 1);
    tick();
    chk("s3_block", dut.cache[1][0][154:27], 128'hFEEDFACE_DEADBEAF_CAFEBABE_77778888);
    chk("s3_dirty", dut.cache[1][0][1], 1);
    chk("s3_way1_tag", dut.cache[1][1][26:2], 25'h02BBBB);

    // Scenario 4: read hits on set 0 way0
    drive(5'd0, 25'h1ABCDE, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    tick();
    chk("s4_read_w0", data_out, 32'hAABBCCDD);
    drive(5'd0, 25'h1ABCDE, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    tick();
    chk("s4_read_w2", data_out, 32'h11112222);

    // Scenario 5: reset clears valid/dirty and registered outputs
    rst = 1'b1;
    drive(5'd0, 25'h1ABCDE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("s5_data_out", data_out, 0);
    chk("s5_dirty_block_out", dirty_block_out, 0);
    chk("s5_hit_1abcde", hit, 0);
    drive(5'd0, 25'h012345, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    chk("s5_hit_12345", hit, 0);
    drive(5'd1, 25'h02CCCC, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    chk("s5_hit_2cccc", hit, 0);
    chk("s5_dirty_bit", dirty_bit, 0);
    drive(5'd1, 25'h02BBBB, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    chk("s5_hit_2bbbb", hit, 0);

    // Scenario 6: invalid ways are filled lowest first; refill on hit reuses way
    drive(5'd3, 25'h000111, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 128'h1);
    chk("s6_first_way", dut.accessed_way, 0);
    tick();
    drive(5'd3, 25'h000222, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 128'h2);
    chk("s6_second_miss", hit, 0);
    chk("s6_second_way", dut.accessed_way, 1);
    tick();
    drive(5'd3, 25'h000111, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    chk("s6_hit_111", hit, 1);
    tick();
    chk("s6_read_111", data_out, 32'h1);
    drive(5'd3, 25'h000222, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    chk("s6_hit_222_way", dut.accessed_way, 1);
    drive(5'd3, 25'h000111, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 128'h3);
    chk("s6_rerefill_way", dut.accessed_way, 0);
    tick();
    chk("s6_rerefill_block", dut.cache[3][0][154:27], 128'h3);
    chk("s6_way1_kept", dut.cache[3][1][26:2], 25'h000222);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
